uart_status_reporter: RTL
=========================

Name: uart_status_reporter

Overview:
- Transmit-side counterpart to the UART command decoder that sets DAC control from received characters.
- On request, snapshots the current DAC control code and frequency word and formats them as an ASCII status line. Example: "R:108\r\n".
- Feeds the line byte-by-byte into the UART2 transmit handshake (TxData/TxSend/TxBusy).
- Sits in Top between the DAC control registers and UART2's transmit port.

Parameters:
SEP_CHAR, 8'h3A (":"), separator byte sent after the status character.
EOL_LF, 1, 1 = terminate with CR LF (7-byte line); 0 = CR only (6-byte line).

Ports:
ipClk  in  1  system clock; everything on rising edge.
ipReset  in  1  asynchronous, active-high reset.
ipTrigger  in  1  request a status line; sampled each cycle, level-high = one request per cycle.
ipControl  in  2  DAC control code: 00 stop, 01 start, 10 pause, 11 invalid.
ipFreq  in  8  DAC frequency word, 0..255.
opTxData  out  8  byte to UART2 ipTxData.
opTxSend  out  1  to UART2 ipTxSend; registered.
ipTxBusy  in  1  from UART2 opTxBusy.
opBusy  out  1  high whenever state != IDLE.
opDone  out  1  one-cycle pulse after the last byte of a line completes.
opOverrun  out  1  one-cycle pulse when a request is dropped.

Behaviour:
- Reset (async):
  - state IDLE; opTxData 8'h00; opTxSend, opBusy, opDone, opOverrun all 0.
  - pending flag 0; byte index 0.
  - Reset mid-line abandons the line; opTxSend drops immediately.
- Line format, bytes in order:
  - status char: 00 'S'(53h), 01 'R'(52h), 10 'P'(50h), 11 '?'(3Fh);
  - SEP_CHAR;
  - hundreds, tens, units of ipFreq as ASCII '0'+digit, always 3 digits with leading zeros;
  - 0Dh;
  - 0Ah only if EOL_LF=1.
- Snapshot: ipControl/ipFreq are latched on the edge that leaves IDLE, or the edge that leaves DONE with pending set. Input changes afterwards do not affect the line in flight.
- FSM:
  - IDLE: ipTrigger=1 -> snapshot, hundreds=tens=0, rem=ipFreq, go CONV_H.
  - CONV_H: per cycle, if rem>=100 then rem-=100 and hundreds++; else go CONV_T.
  - CONV_T: per cycle, if rem>=10 then rem-=10 and tens++; else units=rem, index=0, go SEND.
  - SEND: opTxData=byte[index]. If ipTxBusy=0, set opTxSend<=1. Once opTxSend=1 and ipTxBusy=1, clear opTxSend<=0 and go WAIT_TX. opTxSend is never asserted while ipTxBusy=1 before acceptance; it waits indefinitely.
  - WAIT_TX: wait for ipTxBusy=0. Then if index=last, go DONE; else index++ and go SEND.
  - DONE: opDone=1 for this cycle. If pending: clear pending, snapshot, go CONV_H. Else go IDLE.
- Conversion latency: (hundreds+1)+(tens+1) cycles. The first opTxSend rises at most 13 cycles after the trigger edge, provided ipTxBusy=0.
- Requests while opBusy=1:
  - If pending=0, set pending.
  - If pending=1, pulse opOverrun and drop the request.
  - A trigger in the DONE cycle counts as a pending request.
  - At most one queued line.
- opTxData holds its value from SEND entry through WAIT_TX; it is unchanged in IDLE.
- Digit arithmetic: rem is 8-bit; hundreds 0..2; tens and units 0..9. No division operator.

Test Plan:
- Reset:
  - Stimulus: hold ipReset high, toggle ipTrigger and ipTxBusy.
  - Required: all outputs 0, no opTxSend.
  - Stimulus: release reset with ipTrigger=0.
  - Required: outputs stay 0.
- Nominal line:
  - Stimulus: ipControl=01, ipFreq=108, one-cycle trigger. UART model raises busy 1 cycle after send and holds it 20 cycles.
  - Required: bytes 52 3A 31 30 38 0D 0A, one opTxSend pulse per byte, single opDone after the last busy fall, opBusy low the next cycle.
- Bounds:
  - Stimulus: ipControl=00, ipFreq=0, EOL_LF=0.
  - Required: 53 3A 30 30 30 0D, 6 bytes only.
  - Stimulus: ipControl=11, ipFreq=255.
  - Required: 3F 3A 32 35 35 0D 0A; first opTxSend exactly 10 cycles after the trigger edge.
- Queueing:
  - Stimulus: trigger at start of line 1; change ipFreq to 42 mid-line; trigger again during byte 2; trigger a third time.
  - Required: line 1 unaffected by the ipFreq change; line 2 "R:042\r\n" follows DONE; exactly one opOverrun pulse on the third trigger; 2 opDone total.
- Busy gating:
  - Stimulus: ipTxBusy held high when triggered.
  - Required: opTxSend stays 0 until busy falls, then asserts on the next edge.
- Reset mid-line:
  - Stimulus: assert ipReset during byte 3's SEND state.
  - Required: opTxSend and opBusy go 0 asynchronously.
  - Stimulus: release reset, then trigger.
  - Required: a complete 7-byte line.

Source files
------------

// File: rtl/uart_status_reporter.sv
// uart_status_reporter: snapshots DAC control/frequency and sends it as an ASCII
// status line ("R:108\r\n") through the UART2 TxData/TxSend/TxBusy handshake.
module uart_status_reporter #(
    parameter logic [7:0] SEP_CHAR = 8'h3A,
    parameter bit         EOL_LF   = 1'b1
) (
    input  logic       ipClk,
    input  logic       ipReset,
    input  logic       ipTrigger,
    input  logic [1:0] ipControl,
    input  logic [7:0] ipFreq,
    output logic [7:0] opTxData,
    output logic       opTxSend,
    input  logic       ipTxBusy,
    output logic       opBusy,
    output logic       opDone,
    output logic       opOverrun
);
    typedef enum logic [2:0] {IDLE, CONV_H, CONV_T, SEND, WAIT_TX, DONE} state_t;
    localparam logic [2:0] LAST = EOL_LF ? 3'd6 : 3'd5;

    state_t     r_state;
    logic [1:0] r_ctrl;
    logic [7:0] r_rem;
    logic [1:0] r_hund;
    logic [3:0] r_tens;
    logic [3:0] r_units;
    logic [2:0] r_idx;
    logic       r_pending;
    logic       w_start;
    logic       w_req_busy;

    function automatic logic [7:0] byte_at(input logic [2:0] idx, input logic [1:0] ctrl,
                                           input logic [1:0] h, input logic [3:0] t, input logic [3:0] u);
        logic [7:0] status;
        status = ctrl == 2'd0 ? 8'h53 : ctrl == 2'd1 ? 8'h52 : ctrl == 2'd2 ? 8'h50 : 8'h3F;
        return idx == 3'd0 ? status :
               idx == 3'd1 ? SEP_CHAR :
               idx == 3'd2 ? 8'h30 + {6'd0, h} :
               idx == 3'd3 ? 8'h30 + {4'd0, t} :
               idx == 3'd4 ? 8'h30 + {4'd0, u} :
               idx == 3'd5 ? 8'h0D : 8'h0A;
    endfunction

    // A trigger in DONE is treated like a queued request and restarts immediately.
    assign w_start    = (r_state == IDLE && ipTrigger) || (r_state == DONE && (r_pending || ipTrigger));
    assign w_req_busy = ipTrigger && r_state != IDLE && r_state != DONE;
    assign opBusy     = r_state != IDLE;
    assign opDone     = r_state == DONE;

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            r_state   <= IDLE;
            r_ctrl    <= 2'd0;
            r_rem     <= 8'd0;
            r_hund    <= 2'd0;
            r_tens    <= 4'd0;
            r_units   <= 4'd0;
            r_idx     <= 3'd0;
            r_pending <= 1'b0;
            opTxData  <= 8'h00;
            opTxSend  <= 1'b0;
            opOverrun <= 1'b0;
        end else begin
            opOverrun <= 1'b0;
            if (w_req_busy) begin
                if (r_pending)
                    opOverrun <= 1'b1;
                else
                    r_pending <= 1'b1;
            end
            if (w_start) begin
                r_ctrl  <= ipControl;
                r_rem   <= ipFreq;
                r_hund  <= 2'd0;
                r_tens  <= 4'd0;
                r_state <= CONV_H;
            end
            case (r_state)
                CONV_H: begin
                    if (r_rem >= 8'd100) begin
                        r_rem  <= r_rem - 8'd100;
                        r_hund <= r_hund + 2'd1;
                    end else
                        r_state <= CONV_T;
                end
                CONV_T: begin
                    if (r_rem >= 8'd10) begin
                        r_rem  <= r_rem - 8'd10;
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        r_units  <= r_rem[3:0];
                        r_idx    <= 3'd0;
                        opTxData <= byte_at(3'd0, r_ctrl, r_hund, r_tens, r_rem[3:0]);
                        r_state  <= SEND;
                    end
                end
                SEND: begin
                    if (opTxSend && ipTxBusy) begin
                        opTxSend <= 1'b0;
                        r_state  <= WAIT_TX;
                    end else if (!ipTxBusy)
                        opTxSend <= 1'b1;
                end
                WAIT_TX: begin
                    if (!ipTxBusy) begin
                        if (r_idx == LAST)
                            r_state <= DONE;
                        else begin
                            r_idx    <= r_idx + 3'd1;
                            opTxData <= byte_at(r_idx + 3'd1, r_ctrl, r_hund, r_tens, r_units);
                            r_state  <= SEND;
                        end
                    end
                end
                DONE: begin
                    r_pending <= r_pending && ipTrigger;
                    if (!w_start)
                        r_state <= IDLE;
                end
                default: ;
            endcase
        end
    end
endmodule
